// File: rtl/fsqrt_unit_if.sv
// Handshake bundle between the FPU (master) and the fsqrt responder (slave).
interface fsqrt_unit_if;
    logic [31:0] input_a;
    logic        enable;
    logic [31:0] output_z;
    logic        out_stb;
    logic        busy;

    modport master (output input_a, enable, input output_z, out_stb, busy);
    modport slave  (input input_a, enable, output output_z, out_stb, busy);
endinterface

// File: rtl/fsqrt_unit.sv
// Iterative binary32 square root (FSQRT.S), RNE only, restoring recurrence.
// One root bit per cycle; result held in DONE until enable is released.
module fsqrt_unit #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000,
    parameter int          ITERS     = 25
) (
    input  logic g_clk,
    input  logic g_rst,
    fsqrt_unit_if.slave bus
);
    localparam int RW   = 2 * ITERS;
    localparam int REMW = ITERS + 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_NORM   = 3'd2;
    localparam logic [2:0] S_ITER   = 3'd3;
    localparam logic [2:0] S_ROUND  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state;
    logic [31:0]       a_q;
    logic [23:0]       mant;
    logic signed [9:0] expo;
    logic [RW-1:0]     rad;
    logic [REMW-1:0]   rem;
    logic [ITERS-1:0]  root;
    logic [4:0]        cnt;
    logic [7:0]        res_exp;
    logic [31:0]       z_q;
    logic              stb_q;

    assign bus.output_z = z_q;
    assign bus.out_stb  = stb_q;
    assign bus.busy     = (state != S_IDLE);

    // Operand fields of the captured value
    logic       a_sgn;
    logic [7:0] a_exp;
    logic [22:0] a_frc;
    assign a_sgn = a_q[31];
    assign a_exp = a_q[30:23];
    assign a_frc = a_q[22:0];

    // Normalisation step and exponent preparation on entry to ITER
    logic [23:0]       m_sh;
    logic signed [9:0] e_sh;
    logic [23:0]       prep_m;
    logic signed [9:0] prep_e;
    logic signed [9:0] e_even;
    logic signed [9:0] e_res;
    logic [24:0]       m25;
    logic [RW-1:0]     prep_rad;

    always_comb begin
        m_sh   = {mant[22:0], 1'b0};
        e_sh   = expo - 10'sd1;
        prep_m = m_sh;
        prep_e = e_sh;
        if (state == S_UNPACK) begin
            prep_m = {1'b1, a_frc};
            prep_e = $signed({2'b00, a_exp}) - 10'sd127;
        end
        // An odd exponent is folded into the radicand so the root exponent is exact
        m25      = prep_e[0] ? {prep_m, 1'b0} : {1'b0, prep_m};
        e_even   = prep_e - {9'd0, prep_e[0]};
        e_res    = (e_even >>> 1) + 10'sd127;
        prep_rad = {m25, {(RW-25){1'b0}}};
    end

    // One restoring step: bring down two radicand bits, try root*4+1
    logic [REMW-1:0] rem_sh;
    logic [REMW-1:0] trial;
    logic            take;

    always_comb begin
        rem_sh = {rem[REMW-3:0], rad[RW-1:RW-2]};
        trial  = {1'b0, root, 2'b01};
        take   = (rem_sh >= trial);
    end

    // RNE from round bit root[0] and sticky remainder
    logic        sticky;
    logic        inc;
    logic [24:0] mant_r;
    logic [7:0]  exp_r;

    always_comb begin
        sticky = (rem != '0);
        inc    = root[0] & (sticky | root[1]);
        mant_r = {1'b0, root[ITERS-1:1]} + {24'd0, inc};
        exp_r  = res_exp + {7'd0, mant_r[24]};
    end

    always_ff @(posedge g_clk or negedge g_rst) begin
        if (!g_rst) begin
            state   <= S_IDLE;
            a_q     <= '0;
            mant    <= '0;
            expo    <= '0;
            rad     <= '0;
            rem     <= '0;
            root    <= '0;
            cnt     <= '0;
            res_exp <= '0;
            z_q     <= '0;
            stb_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.enable) begin
                        a_q   <= bus.input_a;
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (bus.enable) begin
                        state <= S_IDLE;
                    end else if (a_exp == 8'hFF) begin
                        z_q   <= (a_frc != '0 || a_sgn) ? CANON_NAN : 32'h7F800000;
                        stb_q <= 1'b1;
                        state <= S_DONE;
                    end else if (a_exp == 8'h00 && a_frc == '0) begin
                        z_q   <= {a_sgn, 31'd0};
                        stb_q <= 1'b1;
                        state <= S_DONE;
                    end else if (a_sgn) begin
                        z_q   <= CANON_NAN;
                        stb_q <= 1'b1;
                        state <= S_DONE;
                    end else if (a_exp == 8'h00) begin
                        mant  <= {1'b0, a_frc};
                        expo  <= -10'sd126;
                        state <= S_NORM;
                    end else begin
                        rad     <= prep_rad;
                        res_exp <= e_res[7:0];
                        rem     <= '0;
                        root    <= '0;
                        cnt     <= '0;
                        state   <= S_ITER;
                    end
                end
                S_NORM: begin
                    if (bus.enable) begin
                        state <= S_IDLE;
                    end else if (m_sh[23]) begin
                        rad     <= prep_rad;
                        res_exp <= e_res[7:0];
                        rem     <= '0;
                        root    <= '0;
                        cnt     <= '0;
                        state   <= S_ITER;
                    end else begin
                        mant <= m_sh;
                        expo <= e_sh;
                    end
                end
                S_ITER: begin
                    if (bus.enable) begin
                        state <= S_IDLE;
                    end else begin
                        rem  <= take ? rem_sh - trial : rem_sh;
                        root <= {root[ITERS-2:0], take};
                        rad  <= {rad[RW-3:0], 2'b00};
                        cnt  <= cnt + 5'd1;
                        if (cnt == 5'(ITERS - 1)) state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (bus.enable) begin
                        state <= S_IDLE;
                    end else begin
                        z_q   <= {1'b0, exp_r, mant_r[22:0]};
                        stb_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.enable) begin
                        stb_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    stb_q <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsqrt_unit.sv
// Directed and randomized checks of fsqrt_unit against a real-arithmetic model.
module tb_fsqrt_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fsqrt_unit_if bus ();
    fsqrt_unit dut (.g_clk(clk), .g_rst(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    // sqrt in double then RNE down to binary32 (double rounding is safe for sqrt)
    function automatic logic [31:0] ref_sqrt(input logic [31:0] a);
        logic [7:0] ex = a[30:23];
        logic [22:0] fr = a[22:0];
        logic [63:0] b;
        logic [23:0] f;
        logic [28:0] rest;
        int fexp, m, e2;
        real v;
        if (ex == 8'hFF) return (fr != 0 || a[31]) ? 32'h7FC00000 : 32'h7F800000;
        if (ex == 0 && fr == 0) return {a[31], 31'd0};
        if (a[31]) return 32'h7FC00000;
        m  = (ex == 0) ? int'(fr) : int'({1'b1, fr});
        e2 = (ex == 0) ? -149 : int'(ex) - 150;
        v  = real'(m) * pow2(e2);
        b  = $realtobits($sqrt(v));
        fexp = int'(b[62:52]) - 1023 + 127;
        rest = b[28:0];
        f = {1'b0, b[51:29]};
        if (rest > 29'h10000000 || (rest == 29'h10000000 && b[29])) f = f + 24'd1;
        if (f[23]) fexp = fexp + 1;
        return {1'b0, 8'(fexp), f[22:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a);
        int l = 1;
        if (a[30:23] == 8'hFF || a[30:0] == 0 || a[31]) return 2;
        if (a[30:23] != 0) return 28;
        for (int k = 22; k >= 0 && !a[k]; k--) l++;
        return 28 + l;
    endfunction

    task automatic run_op(input logic [31:0] a, input string tag);
        int ecnt = 1;
        logic [31:0] z, want;
        want = ref_sqrt(a);
        @(negedge clk);
        bus.input_a = a;
        bus.enable  = 1'b0;
        @(posedge clk);
        #1 bus.input_a = $urandom();
        while (bus.out_stb !== 1'b1 && ecnt < 100) begin
            @(posedge clk);
            ecnt++;
            #1;
        end
        chk({tag, "_timeout"}, {31'd0, ecnt < 100}, 32'd1);
        chk({tag, "_latency"}, ecnt, ref_lat(a));
        chk({tag, "_z"}, bus.output_z, want);
        chk({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
        z = bus.output_z;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold_stb"}, {31'd0, bus.out_stb}, 32'd1);
        chk({tag, "_hold_z"}, bus.output_z, z);
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_rel_stb"}, {31'd0, bus.out_stb}, 32'd0);
        chk({tag, "_rel_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_rel_z"}, bus.output_z, z);
    endtask

    initial begin
        logic [31:0] prev_z, a;
        bus.input_a = '0;
        bus.enable  = 1'b1;
        #12;
        chk("rst_stb", {31'd0, bus.out_stb}, 32'd0);
        chk("rst_z", bus.output_z, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_op(32'h40800000, "sqrt4");
        chk("sqrt4_const", bus.output_z, 32'h40000000);
        run_op(32'h40000000, "sqrt2");
        chk("sqrt2_const", bus.output_z, 32'h3FB504F3);
        run_op(32'h41100000, "sqrt9");
        chk("sqrt9_const", bus.output_z, 32'h40400000);
        run_op(32'hBF800000, "neg1");
        chk("neg1_const", bus.output_z, 32'h7FC00000);
        run_op(32'h80000000, "negzero");
        run_op(32'h00000000, "poszero");
        run_op(32'h7F800000, "posinf");
        run_op(32'h7F800001, "snan");
        run_op(32'hFF800000, "neginf");
        run_op(32'h7FC12345, "qnan");
        run_op(32'h00000001, "submin");
        chk("submin_const", bus.output_z, 32'h1A3504F3);
        run_op(32'h00400000, "subl1");
        run_op(32'h007FFFFF, "submax");
        run_op(32'h7F7FFFFF, "maxnorm");
        run_op(32'h00800000, "minnorm");

        // Abort mid-ITER, then restart
        prev_z = bus.output_z;
        @(negedge clk);
        bus.input_a = 32'h40800000;
        bus.enable  = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            if (bus.out_stb !== 1'b0) chk("abort_stb_run", {31'd0, bus.out_stb}, 32'd0);
        end
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_stb", {31'd0, bus.out_stb}, 32'd0);
        chk("abort_z", bus.output_z, prev_z);
        run_op(32'h41100000, "restart9");

        // Asynchronous reset mid-ITER
        @(negedge clk);
        bus.input_a = 32'h40000000;
        bus.enable  = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stb", {31'd0, bus.out_stb}, 32'd0);
        chk("arst_z", bus.output_z, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        bus.enable = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("arst_idle_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_idle_stb", {31'd0, bus.out_stb}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom();
                1: a = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())};
                2: a = {9'd0, 23'($urandom_range(1, 32'h7FFFFF))};
                default: a = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom())};
            endcase
            run_op(a, $sformatf("rnd%0d_%h", i, a));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
